// File: rtl/arb_rr_mc.sv
// ---------------------------------------------------------------------------
// arb_rr_mc -- per-output-port switch arbiter for the NoC router.
//
// Arbitrates among N_PORT input ports for one output port. Multicast requests
// have class priority over unicast. Within a class the winner is picked
// round-robin (RR_EN=1) or by fixed priority, highest index first (RR_EN=0).
// A packet that starts with a non-tail flit locks the output to its owner
// until the tail flit is transferred (wormhole switching). An aging counter
// forces one unicast packet through after AGE_MAX back-to-back multicast
// packets that were completed while unicast was waiting.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   u_req      [N_PORT] unicast request per input port
//   m_req      [N_PORT] multicast request per input port
//   multab_ct  [N_PORT] multicast/absorb contention; 1 masks that port's
//              multicast grant this cycle
//   fire       the granted port's flit crosses the crossbar this cycle
//   tail       the flit moved under fire is a tail flit
//   grt        [N_PORT] one-hot or zero grant (combinational)
//   grt_id     [IDW] index of the current owner/winner; valid when |grt
//   locked     registered; 1 while a multi-flit packet holds the output
// ---------------------------------------------------------------------------
module arb_rr_mc #(
  parameter int N_PORT  = 5,
  parameter int RR_EN   = 1,
  parameter int AGE_MAX = 8,
  parameter int IDW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_PORT-1:0] u_req,
  input  logic [N_PORT-1:0] m_req,
  input  logic [N_PORT-1:0] multab_ct,
  input  logic              fire,
  input  logic              tail,
  output logic [N_PORT-1:0] grt,
  output logic [IDW-1:0]    grt_id,
  output logic              locked
);

  localparam int AW = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOCK_U, LOCK_M} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    ptr, ptr_nxt;
  logic [IDW-1:0]    owner, owner_nxt;
  logic [AW-1:0]     age, age_nxt;
  logic              locked_nxt;

  logic [N_PORT-1:0] cand_m, cand;
  logic              force_u, cls_mc;
  logic              win_found;
  logic [IDW-1:0]    win_idx;

  logic [N_PORT-1:0] grt_c;
  logic [IDW-1:0]    grt_id_c;
  logic              done, done_mc;
  logic [IDW-1:0]    done_port;

  // Port index base+k, wrapped into 0..N_PORT-1 (base is always < N_PORT).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return IDW'(s % N_PORT);
  endfunction

  // ---------------------------------------------------------------------
  // Class and winner selection (only used in IDLE).
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    cand_m    = m_req & ~multab_ct;
    force_u   = (AGE_MAX != 0) && (age == AW'(AGE_MAX)) && (|u_req);
    // Multicast wins the class even if all its ports are masked: a masked
    // cycle is a bubble, never a same-cycle fallback to unicast.
    cls_mc    = (|m_req) && !force_u;
    cand      = cls_mc ? cand_m : u_req;
    win_found = 1'b0;
    win_idx   = '0;
    if (RR_EN != 0) begin
      for (int k = 0; k < N_PORT; k++) begin
        if (!win_found && cand[wrap_add(ptr, k)]) begin
          win_found = 1'b1;
          win_idx   = wrap_add(ptr, k);
        end
      end
    end else begin
      // Ascending scan, last hit kept: highest index wins.
      for (int k = 0; k < N_PORT; k++) begin
        if (cand[k]) begin
          win_found = 1'b1;
          win_idx   = IDW'(k);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and grant logic.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    locked_nxt = locked;
    grt_c      = '0;
    grt_id_c   = '0;
    done       = 1'b0;
    done_mc    = 1'b0;
    done_port  = owner;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          grt_c[win_idx] = 1'b1;
          grt_id_c       = win_idx;
          if (fire) begin
            if (tail) begin
              done      = 1'b1;
              done_mc   = cls_mc;
              done_port = win_idx;
            end else begin
              owner_nxt  = win_idx;
              state_nxt  = cls_mc ? LOCK_M : LOCK_U;
              locked_nxt = 1'b1;
            end
          end
        end
      end
      LOCK_U, LOCK_M: begin
        // Owner's grant only; a dropped request is a bubble, the lock stays.
        grt_id_c = owner;
        if ((state == LOCK_U) ? u_req[owner] : (m_req[owner] && !multab_ct[owner])) begin
          grt_c[owner] = 1'b1;
          if (fire && tail) begin
            state_nxt  = IDLE;
            locked_nxt = 1'b0;
            done       = 1'b1;
            done_mc    = (state == LOCK_M);
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        locked_nxt = 1'b0;
      end
    endcase

    // Packet-complete update: rotate past the finished owner and track how
    // many multicast packets in a row went by while unicast was waiting.
    ptr_nxt = ptr;
    age_nxt = age;
    if (done) begin
      ptr_nxt = (int'(done_port) == N_PORT - 1) ? '0 : done_port + 1'b1;
      if (done_mc && (|u_req))
        age_nxt = (age == AW'(AGE_MAX)) ? age : age + 1'b1;
      else
        age_nxt = '0;
    end
  end

  // ---------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples values from before this edge regardless of block order.
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      age    <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      owner  <= owner_nxt;
      age    <= age_nxt;
      locked <= locked_nxt;
    end
  end

  // Outputs are gated by reset so no grant leaks out while rst is held.
  assign grt    = rst ? '0 : grt_c;
  assign grt_id = rst ? '0 : grt_id_c;

endmodule
